// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment display paths: active-low glyphs,
// blank/off patterns, digit count and the scan-slot encoding.
package seg7_pkg;

    localparam int NDIG = 3;

    localparam logic [6:0]      SEG_OFF = 7'b1111111;
    localparam logic [NDIG-1:0] AN_OFF  = 3'b111;

    // {g,f,e,d,c,b,a}, active-low; 10..15 render as A b C d E F
    localparam logic [6:0] GLYPH [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    typedef enum logic [1:0] {
        SLOT_ONES = 2'd0,
        SLOT_TENS = 2'd1,
        SLOT_HUND = 2'd2
    } slot_e;

    function automatic logic [NDIG-1:0] anode_sel(input slot_e s);
        return ~(NDIG'(1) << s);
    endfunction

endpackage

// File: rtl/seg7_scanner_if.sv
// Digit inputs from the counter and the multiplexed display outputs.
interface seg7_scanner_if;
    logic [3:0] CNT1;
    logic [3:0] CNT2;
    logic [3:0] CNT3;
    logic [6:0] SEG;
    logic [2:0] AN;

    modport master (output CNT1, CNT2, CNT3, input SEG, AN);
    modport slave  (input CNT1, CNT2, CNT3, output SEG, AN);
endinterface

// File: rtl/seg7_decode.sv
// Combinational 4-bit code to active-low glyph, with a forced-blank input.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] code_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_OFF;
        if (!blank_i) begin
            seg_o = GLYPH[code_i];
        end
    end

endmodule

// File: rtl/seg7_scanner.sv
// 3-digit common-anode display scanner with per-frame digit capture and a dark
// gap per slot. Define SEG7_LZB_EN to enable leading-zero blanking.
module seg7_scanner
    import seg7_pkg::*;
#(
    parameter int DIV   = 50000,
    parameter int BLANK = 500
) (
    input  logic           CLK,
    input  logic           RESET_N,
    seg7_scanner_if.slave  bus
);

    localparam int            PW         = $clog2(DIV);
    localparam logic [PW-1:0] PCNT_LAST  = PW'(DIV - 1);
    localparam logic [PW-1:0] PCNT_BLANK = PW'(BLANK);

    logic [PW-1:0]         pcnt_q, pcnt_d;
    slot_e                 idx_q, idx_d;
    logic [NDIG-1:0][3:0]  sh_q, sh_d, cnt_in;
    logic [6:0]            seg_q, seg_d;
    logic [NDIG-1:0]       an_q, an_d;
    logic                  tick;
    logic                  capture;
    logic [3:0]            cur_code;
    logic                  cur_blank;
    logic [6:0]            cur_glyph;

    assign cnt_in[0] = bus.CNT1;
    assign cnt_in[1] = bus.CNT2;
    assign cnt_in[2] = bus.CNT3;

    assign tick    = (pcnt_q == PCNT_LAST);
    assign capture = tick && (idx_q == SLOT_HUND);
    assign pcnt_d  = tick ? '0 : pcnt_q + PW'(1);

    always_comb begin
        idx_d = idx_q;
        if (tick) begin
            case (idx_q)
                SLOT_ONES: idx_d = SLOT_TENS;
                SLOT_TENS: idx_d = SLOT_HUND;
                default:   idx_d = SLOT_ONES;
            endcase
        end
    end

    // Capture coincides with the 2->0 wrap so slot 0 of a frame already shows new data
    generate
        for (genvar gi = 0; gi < NDIG; gi++) begin : g_shadow
            assign sh_d[gi] = capture ? cnt_in[gi] : sh_q[gi];
        end
    endgenerate

    always_comb begin
        cur_code = sh_q[0];
        case (idx_q)
            SLOT_TENS: cur_code = sh_q[1];
            SLOT_HUND: cur_code = sh_q[2];
            default:   cur_code = sh_q[0];
        endcase
    end

`ifdef SEG7_LZB_EN
    always_comb begin
        cur_blank = 1'b0;
        case (idx_q)
            SLOT_HUND: cur_blank = (sh_q[2] == 4'd0);
            SLOT_TENS: cur_blank = (sh_q[2] == 4'd0) && (sh_q[1] == 4'd0);
            default:   cur_blank = 1'b0;
        endcase
    end
`else
    assign cur_blank = 1'b0;
`endif

    seg7_decode u_decode (
        .code_i  (cur_code),
        .blank_i (cur_blank),
        .seg_o   (cur_glyph)
    );

    always_comb begin
        seg_d = SEG_OFF;
        an_d  = AN_OFF;
        if (pcnt_q >= PCNT_BLANK) begin
            seg_d = cur_glyph;
            an_d  = anode_sel(idx_q);
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            pcnt_q <= '0;
            idx_q  <= SLOT_ONES;
            sh_q   <= '0;
            seg_q  <= SEG_OFF;
            an_q   <= AN_OFF;
        end else begin
            pcnt_q <= pcnt_d;
            idx_q  <= idx_d;
            sh_q   <= sh_d;
            seg_q  <= seg_d;
            an_q   <= an_d;
        end
    end

    assign bus.SEG = seg_q;
    assign bus.AN  = an_q;

endmodule

// File: tb/tb_seg7_scanner.sv
// Directed bench for seg7_scanner with DIV=8, BLANK=2 (24-clock frames).
module tb_seg7_scanner;

    localparam int DIV   = 8;
    localparam int BLANK = 2;
    localparam int FRAME = 3 * DIV;

    logic CLK     = 1'b0;
    logic RESET_N = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    seg7_scanner_if bus();

    seg7_scanner #(.DIV(DIV), .BLANK(BLANK)) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .bus     (bus)
    );

    always #5 CLK = ~CLK;

    function automatic logic [6:0] glyph_of(input logic [3:0] c);
        case (c)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    // j = clock index within the frame whose state produced the current outputs
    function automatic logic [2:0] exp_an(input int j);
        int ph;
        int sl;
        ph = j % DIV;
        sl = j / DIV;
        if (ph < BLANK) return 3'b111;
        if (sl == 0) return 3'b110;
        if (sl == 1) return 3'b101;
        return 3'b011;
    endfunction

    function automatic logic [6:0] exp_seg(input int j, input logic [3:0] d1,
                                           input logic [3:0] d2, input logic [3:0] d3);
        int ph;
        int sl;
        logic [3:0] d;
        logic blank;
        ph = j % DIV;
        sl = j / DIV;
        blank = 1'b0;
        if (ph < BLANK) return 7'b1111111;
        d = (sl == 0) ? d1 : ((sl == 1) ? d2 : d3);
`ifdef SEG7_LZB_EN
        if (sl == 2 && d3 == 4'd0) blank = 1'b1;
        if (sl == 1 && d3 == 4'd0 && d2 == 4'd0) blank = 1'b1;
`endif
        return blank ? 7'b1111111 : glyph_of(d);
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_cnt(input logic [3:0] c1, input logic [3:0] c2, input logic [3:0] c3);
        bus.CNT1 = c1;
        bus.CNT2 = c2;
        bus.CNT3 = c3;
    endtask

    task automatic test_reset();
        set_cnt(4'd1, 4'd2, 4'd3);
        #1 RESET_N = 1'b0;
        #1;
        n_tests++;
        if (bus.AN !== 3'b111 || bus.SEG !== 7'b1111111) begin
            n_fail++;
            $display("FAIL reset_async AN=%b SEG=%b required AN=111 SEG=1111111", bus.AN, bus.SEG);
        end
        repeat (2) step();
        n_tests++;
        if (bus.AN !== 3'b111 || bus.SEG !== 7'b1111111) begin
            n_fail++;
            $display("FAIL reset_held AN=%b SEG=%b required AN=111 SEG=1111111", bus.AN, bus.SEG);
        end
        @(negedge CLK);
        RESET_N = 1'b1;
        // frame 0 shows the reset shadows
        for (int j = 0; j < FRAME; j++) begin
            step();
            n_tests++;
            if (bus.AN !== exp_an(j) || bus.SEG !== exp_seg(j, 4'd0, 4'd0, 4'd0)) begin
                n_fail++;
                $display("FAIL reset_frame0 j=%0d AN=%b SEG=%b required AN=%b SEG=%b",
                         j, bus.AN, bus.SEG, exp_an(j), exp_seg(j, 4'd0, 4'd0, 4'd0));
            end
        end
        $display("[TB] test_reset done");
    endtask

    task automatic test_basic();
        int lit0, lit1, lit2, dark;
        for (int f = 0; f < 2; f++) begin
            lit0 = 0; lit1 = 0; lit2 = 0; dark = 0;
            for (int j = 0; j < FRAME; j++) begin
                step();
                if (bus.AN === 3'b110) lit0++;
                if (bus.AN === 3'b101) lit1++;
                if (bus.AN === 3'b011) lit2++;
                if (bus.AN === 3'b111) dark++;
                n_tests++;
                if (bus.AN !== exp_an(j) || bus.SEG !== exp_seg(j, 4'd1, 4'd2, 4'd3)) begin
                    n_fail++;
                    $display("FAIL basic f=%0d j=%0d AN=%b SEG=%b required AN=%b SEG=%b",
                             f, j, bus.AN, bus.SEG, exp_an(j), exp_seg(j, 4'd1, 4'd2, 4'd3));
                end
            end
            n_tests++;
            if (lit0 != 6 || lit1 != 6 || lit2 != 6 || dark != 6) begin
                n_fail++;
                $display("FAIL basic_lit_count f=%0d lit=%0d/%0d/%0d dark=%0d required 6/6/6 dark=6",
                         f, lit0, lit1, lit2, dark);
            end
        end
        $display("[TB] test_basic done");
    endtask

    task automatic test_midframe_change();
        for (int j = 0; j < FRAME; j++) begin
            if (j == 10) bus.CNT1 = 4'd9;
            step();
            n_tests++;
            if (bus.AN !== exp_an(j) || bus.SEG !== exp_seg(j, 4'd1, 4'd2, 4'd3)) begin
                n_fail++;
                $display("FAIL midframe_old j=%0d AN=%b SEG=%b required AN=%b SEG=%b",
                         j, bus.AN, bus.SEG, exp_an(j), exp_seg(j, 4'd1, 4'd2, 4'd3));
            end
        end
        for (int j = 0; j < FRAME; j++) begin
            step();
            n_tests++;
            if (bus.AN !== exp_an(j) || bus.SEG !== exp_seg(j, 4'd9, 4'd2, 4'd3)) begin
                n_fail++;
                $display("FAIL midframe_new j=%0d AN=%b SEG=%b required AN=%b SEG=%b",
                         j, bus.AN, bus.SEG, exp_an(j), exp_seg(j, 4'd9, 4'd2, 4'd3));
            end
        end
        $display("[TB] test_midframe_change done");
    endtask

    task automatic test_capture_edge();
        // CNT1 changes in the very cycle of the capture tick
        for (int j = 0; j < FRAME; j++) begin
            if (j == FRAME - 1) bus.CNT1 = 4'd7;
            step();
            n_tests++;
            if (bus.SEG !== exp_seg(j, 4'd9, 4'd2, 4'd3)) begin
                n_fail++;
                $display("FAIL capture_pre j=%0d SEG=%b required %b", j, bus.SEG, exp_seg(j, 4'd9, 4'd2, 4'd3));
            end
        end
        for (int j = 0; j < FRAME; j++) begin
            step();
            n_tests++;
            if (bus.AN !== exp_an(j) || bus.SEG !== exp_seg(j, 4'd7, 4'd2, 4'd3)) begin
                n_fail++;
                $display("FAIL capture_post j=%0d AN=%b SEG=%b required AN=%b SEG=%b",
                         j, bus.AN, bus.SEG, exp_an(j), exp_seg(j, 4'd7, 4'd2, 4'd3));
            end
        end
        $display("[TB] test_capture_edge done");
    endtask

    task automatic test_lzb();
        set_cnt(4'd5, 4'd0, 4'd0);
        for (int j = 0; j < FRAME; j++) step();
        set_cnt(4'd0, 4'd5, 4'd0);
        for (int j = 0; j < FRAME; j++) begin
            step();
            n_tests++;
            if (bus.AN !== exp_an(j) || bus.SEG !== exp_seg(j, 4'd5, 4'd0, 4'd0)) begin
                n_fail++;
                $display("FAIL lzb_005 j=%0d AN=%b SEG=%b required AN=%b SEG=%b",
                         j, bus.AN, bus.SEG, exp_an(j), exp_seg(j, 4'd5, 4'd0, 4'd0));
            end
        end
        for (int j = 0; j < FRAME; j++) begin
            step();
            n_tests++;
            if (bus.AN !== exp_an(j) || bus.SEG !== exp_seg(j, 4'd0, 4'd5, 4'd0)) begin
                n_fail++;
                $display("FAIL lzb_050 j=%0d AN=%b SEG=%b required AN=%b SEG=%b",
                         j, bus.AN, bus.SEG, exp_an(j), exp_seg(j, 4'd0, 4'd5, 4'd0));
            end
        end
        $display("[TB] test_lzb done");
    endtask

    task automatic test_hex();
        logic [3:0] shown;
        shown = 4'd0;
        for (int v = 10; v <= 16; v++) begin
            if (v <= 15) set_cnt(4'(v), 4'd1, 4'd4);
            for (int j = 0; j < FRAME; j++) begin
                step();
                if (v > 10 && j == DIV - 1) begin
                    n_tests++;
                    if (bus.AN !== 3'b110 || bus.SEG !== glyph_of(shown)) begin
                        n_fail++;
                        $display("FAIL hex code=%h AN=%b SEG=%b required AN=110 SEG=%b",
                                 shown, bus.AN, bus.SEG, glyph_of(shown));
                    end
                end
            end
            shown = 4'(v);
        end
        $display("[TB] test_hex done");
    endtask

    task automatic test_dark();
        int lows;
        for (int j = 0; j < FRAME; j++) begin
            step();
            lows = 0;
            for (int b = 0; b < 3; b++) if (bus.AN[b] === 1'b0) lows++;
            n_tests++;
            if (lows > 1 || ((j % DIV) < BLANK && bus.AN !== 3'b111)) begin
                n_fail++;
                $display("FAIL dark j=%0d AN=%b required at most one low, all high in dark", j, bus.AN);
            end
        end
        $display("[TB] test_dark done");
    endtask

    task automatic test_reset_mid();
        for (int j = 0; j < 12; j++) step();
        n_tests++;
        if (bus.AN !== 3'b101) begin
            n_fail++;
            $display("FAIL reset_mid_lit AN=%b required 101", bus.AN);
        end
        #2 RESET_N = 1'b0;
        #1;
        n_tests++;
        if (bus.AN !== 3'b111 || bus.SEG !== 7'b1111111) begin
            n_fail++;
            $display("FAIL reset_mid_async AN=%b SEG=%b required AN=111 SEG=1111111", bus.AN, bus.SEG);
        end
        repeat (2) step();
        @(negedge CLK);
        RESET_N = 1'b1;
        for (int j = 0; j < FRAME; j++) begin
            step();
            n_tests++;
            if (bus.AN !== exp_an(j) || bus.SEG !== exp_seg(j, 4'd0, 4'd0, 4'd0)) begin
                n_fail++;
                $display("FAIL reset_mid_restart j=%0d AN=%b SEG=%b required AN=%b SEG=%b",
                         j, bus.AN, bus.SEG, exp_an(j), exp_seg(j, 4'd0, 4'd0, 4'd0));
            end
        end
        for (int j = 0; j < FRAME; j++) begin
            step();
            n_tests++;
            if (bus.AN !== exp_an(j) || bus.SEG !== exp_seg(j, 4'hF, 4'd1, 4'd4)) begin
                n_fail++;
                $display("FAIL reset_mid_recapture j=%0d AN=%b SEG=%b required AN=%b SEG=%b",
                         j, bus.AN, bus.SEG, exp_an(j), exp_seg(j, 4'hF, 4'd1, 4'd4));
            end
        end
        $display("[TB] test_reset_mid done");
    endtask

    initial begin
        set_cnt(4'd0, 4'd0, 4'd0);
        test_reset();
        test_basic();
        test_midframe_change();
        test_capture_edge();
        test_lzb();
        test_hex();
        test_dark();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
